// File: rtl/beat_pkg.sv
// Shared types and helpers for the beat-detection path: FSM states,
// magnitude width and the threshold ladder.
package beat_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HOLDOFF
    } state_t;

    localparam int THRESH_BASE_DEF = 2000;
    localparam int THRESH_STEP_DEF = 2000;

    // |dx|+|dy|+|dz| of DATA_W-bit samples always fits in DATA_W+2 bits.
    function automatic int mag_w(input int data_w);
        return data_w + 2;
    endfunction

    function automatic longint threshold(input int k, input longint base, input longint step);
        return base + longint'(k) * step;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock-enable divider: tick_o is high for one clk every CLK_HZ/TICK_HZ cycles,
// on the cycle the counter wraps. Shared by the beat, display and LED blocks.
module tick_gen #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int PERIOD = CLK_HZ / TICK_HZ;
    localparam int CW     = $clog2(PERIOD);

    if (PERIOD < 4) begin : g_bad_period
        $error("tick_gen: CLK_HZ/TICK_HZ must be at least 4");
    end

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(PERIOD - 1));

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/beat_detect_core.sv
// Accelerometer jerk-magnitude beat detector: stages samples, evaluates on a
// periodic tick through a 2-stage pipeline and fires graded beats with holdoff.
module beat_detect_core
    import beat_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int CLK_HZ        = 50000000,
    parameter int TICK_HZ       = 100,
    parameter int INT_W         = 2,
    parameter int THRESH_BASE   = THRESH_BASE_DEF,
    parameter int THRESH_STEP   = THRESH_STEP_DEF,
    parameter int HOLDOFF_TICKS = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_valid,
    input  logic signed [DATA_W-1:0]      x_acc,
    input  logic signed [DATA_W-1:0]      y_acc,
    input  logic signed [DATA_W-1:0]      z_acc,
    output logic                          beat,
    output logic [INT_W-1:0]              beat_int,
    output logic [mag_w(DATA_W)-1:0]      magnitude,
    output logic                          busy_holdoff
);

    localparam int MW     = mag_w(DATA_W);
    localparam int LEVELS = 2 ** INT_W;
    localparam int CNT_W  = INT_W + 1;
    localparam int HW     = (HOLDOFF_TICKS > 0) ? $clog2(HOLDOFF_TICKS + 1) : 1;

    if (threshold(LEVELS - 1, THRESH_BASE, THRESH_STEP) >= (longint'(1) << MW)) begin : g_thr_ovf
        $error("beat_detect_core: threshold ladder overflows magnitude width");
    end

    function automatic logic [DATA_W-1:0] abs_diff(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] d;
        d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        return d[DATA_W] ? DATA_W'(-d) : DATA_W'(d);
    endfunction

    logic                     tick;
    logic signed [DATA_W-1:0] stg_x_q, stg_y_q, stg_z_q;
    logic signed [DATA_W-1:0] prev_x_q, prev_y_q, prev_z_q;
    logic                     fresh_q;
    logic [DATA_W-1:0]        ax_q, ay_q, az_q;
    logic                     s1_vld_q;
    logic [MW-1:0]            sum_c;
    logic [CNT_W-1:0]         met_c;
    state_t                   state_q, state_d;
    logic [HW-1:0]            hold_q, hold_d;
    logic                     beat_q, beat_d;
    logic [INT_W-1:0]         int_q, int_d;
    logic [MW-1:0]            mag_q, mag_d;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    // Ladder is monotonic, so the count of met rungs gives intensity + 1.
    always_comb begin
        sum_c = MW'(ax_q) + MW'(ay_q) + MW'(az_q);
        met_c = '0;
        for (int k = 0; k < LEVELS; k++) begin
            if (sum_c >= MW'(threshold(k, THRESH_BASE, THRESH_STEP))) begin
                met_c = met_c + CNT_W'(1);
            end
        end
    end

    // Tick and stage-2 never share a cycle since the tick period is at least 4.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        beat_d  = 1'b0;
        int_d   = int_q;
        mag_d   = mag_q;
        if (tick && state_q == HOLDOFF) begin
            if (hold_q == '0) begin
                state_d = ARMED;
            end else begin
                hold_d = hold_q - HW'(1);
            end
        end
        if (s1_vld_q) begin
            if (state_q == IDLE) begin
                state_d = ARMED;
            end else begin
                mag_d = sum_c;
                if (state_q == ARMED && met_c != '0) begin
                    beat_d = 1'b1;
                    int_d  = INT_W'(met_c - CNT_W'(1));
                    if (HOLDOFF_TICKS != 0) begin
                        state_d = HOLDOFF;
                        hold_d  = HW'(HOLDOFF_TICKS);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_x_q  <= '0;
            stg_y_q  <= '0;
            stg_z_q  <= '0;
            prev_x_q <= '0;
            prev_y_q <= '0;
            prev_z_q <= '0;
            fresh_q  <= 1'b0;
            ax_q     <= '0;
            ay_q     <= '0;
            az_q     <= '0;
            s1_vld_q <= 1'b0;
            state_q  <= IDLE;
            hold_q   <= '0;
            beat_q   <= 1'b0;
            int_q    <= '0;
            mag_q    <= '0;
        end else begin
            if (sample_valid) begin
                stg_x_q <= x_acc;
                stg_y_q <= y_acc;
                stg_z_q <= z_acc;
            end
            fresh_q  <= sample_valid | (fresh_q & ~tick);
            s1_vld_q <= tick & fresh_q;
            if (tick && fresh_q) begin
                ax_q     <= abs_diff(stg_x_q, prev_x_q);
                ay_q     <= abs_diff(stg_y_q, prev_y_q);
                az_q     <= abs_diff(stg_z_q, prev_z_q);
                prev_x_q <= stg_x_q;
                prev_y_q <= stg_y_q;
                prev_z_q <= stg_z_q;
            end
            state_q <= state_d;
            hold_q  <= hold_d;
            beat_q  <= beat_d;
            int_q   <= int_d;
            mag_q   <= mag_d;
        end
    end

    assign beat         = beat_q;
    assign beat_int     = int_q;
    assign magnitude    = mag_q;
    assign busy_holdoff = (state_q == HOLDOFF);

endmodule

// File: doc/beat_detect_core.md
Name: beat_detect_core

Overview:
- Parametrised successor to the accelerometer-to-beat path.
- Runs on the single system clock, using an internal clock-enable tick instead of a divided clock.
- Takes handshaked 3-axis accelerometer samples from the I2C reader and computes per-tick jerk magnitude |dx|+|dy|+|dz|.
- Compares magnitude against a configurable threshold ladder and emits a one-cycle beat pulse plus a graded intensity, with a refractory holdoff between beats.

Parameters:
- DATA_W, 16, signed width of each axis sample.
- CLK_HZ, 50000000, system clock frequency.
- TICK_HZ, 100, evaluation rate; tick period = CLK_HZ/TICK_HZ cycles (integer, >=4).
- INT_W, 2, intensity width; 2**INT_W levels.
- THRESH_BASE, 2000, magnitude at or above which a beat fires (level 0).
- THRESH_STEP, 2000, magnitude increment per additional intensity level.
- HOLDOFF_TICKS, 20, ticks after a beat during which no beat may fire (0 = no holdoff).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- sample_valid  in  1  one-cycle strobe; x/y/z valid this cycle.
- x_acc  in  DATA_W  signed X sample.
- y_acc  in  DATA_W  signed Y sample.
- z_acc  in  DATA_W  signed Z sample.
- beat  out  1  one-cycle pulse per detected beat.
- beat_int  out  INT_W  intensity of most recent beat; held until the next beat.
- magnitude  out  DATA_W+2  last computed jerk magnitude (debug).
- busy_holdoff  out  1  high while in HOLDOFF.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: beat=0, beat_int=0, magnitude=0, busy_holdoff=0, state=IDLE, all sample/prev registers=0, fresh flag=0, tick counter=0.
- Tick: counter 0..CLK_HZ/TICK_HZ-1; tick is high for one clk when the counter wraps.
- Staging: on sample_valid, capture x/y/z into the staged registers and set fresh=1.
- Tick evaluation: on tick with fresh=1, consume the staged sample and clear fresh. On tick with fresh=0, do nothing: no evaluation, prev unchanged, holdoff still counts.
- Simultaneous sample_valid and tick: the tick consumes the previously staged values. The new sample overwrites staging and fresh stays 1.
- Arithmetic:
  - Per-axis difference computed at DATA_W+1 signed.
  - abs of each difference fits DATA_W unsigned.
  - magnitude = sum of the three abs values at DATA_W+2 unsigned; no overflow is possible.
  - Threshold k = THRESH_BASE + k*THRESH_STEP, computed at DATA_W+2 bits. Parameters must not overflow this width (elaboration check).
  - Intensity = (number of thresholds met) - 1, saturating at 2**INT_W-1.
- Pipeline: stage 1 (tick+1) registers the abs diffs and moves staged to prev; stage 2 (tick+2) registers magnitude and the compare result. beat asserts at tick+2 for exactly one cycle.
- FSM states:
  - IDLE: first consumed sample only loads prev; no beat; go to ARMED.
  - ARMED: evaluate each fresh tick. If magnitude >= THRESH_BASE: beat=1, beat_int updated, holdoff counter = HOLDOFF_TICKS, go to HOLDOFF (stay ARMED if HOLDOFF_TICKS=0).
  - HOLDOFF: evaluations update prev and magnitude but never fire. Counter decrements on every tick; at 0 go to ARMED. A fresh tick coinciding with the counter reaching 0 is evaluated in ARMED rules.
- beat_int changes only in the same cycle beat=1.
- Reset mid-operation: pipeline, holdoff and fresh are discarded immediately; after release, return to IDLE (first sample is reference only).

Decomposition:
- Shared package beat_pkg:
  - State enum {IDLE, ARMED, HOLDOFF}.
  - Function mag_w(DATA_W)=DATA_W+2.
  - Function threshold(k) for the ladder.
  - Constant defaults for THRESH_BASE and THRESH_STEP.
- One sub-module, tick_gen: parametrised CLK_HZ/TICK_HZ clock-enable divider with clk and rst_n. It replaces the divided-clock approach and is reusable by the display and LED blocks.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100 (tick every 10 clk), THRESH_BASE=1000, THRESH_STEP=1000, INT_W=2, HOLDOFF_TICKS=3.
- Reset then samples (0,0,0) and (500,0,0) on consecutive ticks -> no beat; magnitude=500.
- prev (0,0,0), next (1200,-900,0) -> magnitude=2100; beat one cycle at tick+2; beat_int=1; busy_holdoff=1.
- Sample deltas of 5000 on each axis -> magnitude=15000; beat_int saturates at 3. Signed extremes (-32768 then 32767 on all axes) -> magnitude=196605 with no overflow.
- Large delta on the 3 ticks after a beat -> no beat. The fourth tick with delta 1500 -> beat, beat_int=0.
- No sample_valid for 5 ticks -> no evaluation, magnitude unchanged, holdoff still expires. sample_valid coincident with tick -> old staged value evaluated and new value taken next tick.
- rst_n asserted between tick and tick+2 of a qualifying sample -> beat never asserts. After release, the first sample produces no beat even if it differs by 10000.
